// File: rtl/ddr3_traffic_pkg.sv
// ============================================================================
// Module      : ddr3_traffic_pkg
// Description : Shared pattern-mode, LFSR and run-state definitions for the
//               DDR3 traffic checker.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ddr3_traffic_pkg;

    typedef enum logic [1:0] {
        MODE_INC     = 2'd0,
        MODE_LFSR    = 2'd1,
        MODE_WALK    = 2'd2,
        MODE_CHECKER = 2'd3
    } mode_e;

    localparam logic [31:0] C_LFSR_SEED  = 32'hACE1_0001;
    localparam int          C_LFSR_TAP_A = 32;
    localparam int          C_LFSR_TAP_B = 22;
    localparam int          C_LFSR_TAP_C = 2;
    localparam int          C_LFSR_TAP_D = 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    function automatic int full_addr_width(input int bank_w, input int addr_w);
        return bank_w + addr_w;
    endfunction

    // Fibonacci form: taps are 1-based bit positions, new bit enters at bit 0.
    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return {s[30:0], s[C_LFSR_TAP_A-1] ^ s[C_LFSR_TAP_B-1] ^
                         s[C_LFSR_TAP_C-1] ^ s[C_LFSR_TAP_D-1]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/ddr3_pattern_gen.sv
// ============================================================================
// Module      : ddr3_pattern_gen
// Description : Indexed data-pattern source; load restarts at word 0, step
//               advances one word. Used for both write and expected streams.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ddr3_pattern_gen
    import ddr3_traffic_pkg::*;
#(
    parameter int DQ_BITWIDTH = 16
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   load,
    input  logic                   step,
    input  logic [1:0]             mode,
    output logic [DQ_BITWIDTH-1:0] data
);

    localparam int POS_W = (DQ_BITWIDTH > 1) ? $clog2(DQ_BITWIDTH) : 1;

    logic [DQ_BITWIDTH-1:0] idx_q, idx_d;
    logic [31:0]            lfsr_q, lfsr_d;
    logic [POS_W-1:0]       pos_q, pos_d;

    // Walking-one position kept as its own wrap counter so no modulo is needed.
    always_comb begin
        idx_d  = idx_q;
        lfsr_d = lfsr_q;
        pos_d  = pos_q;
        if (load) begin
            idx_d  = '0;
            lfsr_d = C_LFSR_SEED;
            pos_d  = '0;
        end else if (step) begin
            idx_d  = idx_q + 1'b1;
            lfsr_d = lfsr_next(lfsr_q);
            pos_d  = (pos_q == POS_W'(DQ_BITWIDTH-1)) ? '0 : pos_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            idx_q  <= '0;
            lfsr_q <= C_LFSR_SEED;
            pos_q  <= '0;
        end else begin
            idx_q  <= idx_d;
            lfsr_q <= lfsr_d;
            pos_q  <= pos_d;
        end
    end

    always_comb begin
        data = '0;
        case (mode)
            MODE_INC:  data = idx_q;
            MODE_LFSR: data = lfsr_q[DQ_BITWIDTH-1:0];
            MODE_WALK: data[pos_q] = 1'b1;
            default: begin
                for (int b = 0; b < DQ_BITWIDTH; b++) begin
                    data[b] = (b % 2 == 0) ^ idx_q[0];
                end
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/ddr3_traffic_checker.sv
// ============================================================================
// Module      : ddr3_traffic_checker
// Description : Write/read-back pattern checker for the DDR3 controller user
//               port. Optional read watchdog: DDR3_TRAFFIC_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ddr3_traffic_checker
    import ddr3_traffic_pkg::*;
#(
    parameter int DQ_BITWIDTH           = 16,
    parameter int ADDRESS_BITWIDTH      = 15,
    parameter int BANK_ADDRESS_BITWIDTH = 3,
    parameter int NUM_WORDS             = 256,
    parameter int ERR_CNT_WIDTH         = 16
`ifdef DDR3_TRAFFIC_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES        = 4096
`endif
) (
    input  logic                                              clk,
    input  logic                                              resetn,
    input  logic                                              start,
    input  logic [1:0]                                        mode,
    input  logic [BANK_ADDRESS_BITWIDTH+ADDRESS_BITWIDTH-1:0] base_address,
    output logic                                              write_enable,
    output logic                                              read_enable,
    output logic [BANK_ADDRESS_BITWIDTH+ADDRESS_BITWIDTH-1:0] i_user_data_address,
    output logic [DQ_BITWIDTH-1:0]                            i_user_data,
    input  logic                                              ctrl_ready,
    input  logic [DQ_BITWIDTH-1:0]                            o_user_data,
    input  logic                                              o_user_data_valid,
    output logic                                              busy,
    output logic                                              done,
    output logic                                              pass,
    output logic [ERR_CNT_WIDTH-1:0]                          error_count,
`ifdef DDR3_TRAFFIC_TIMEOUT_EN
    output logic                                              timeout,
`endif
    output logic [BANK_ADDRESS_BITWIDTH+ADDRESS_BITWIDTH-1:0] first_err_address
);

    localparam int FA_W = full_addr_width(BANK_ADDRESS_BITWIDTH, ADDRESS_BITWIDTH);
    localparam int IDX_W = $clog2(NUM_WORDS + 1);
    localparam logic [ERR_CNT_WIDTH-1:0] ERR_MAX = '1;

    state_e                   state_q, state_d;
    logic [IDX_W-1:0]         req_idx_q, req_idx_d;
    logic [IDX_W-1:0]         rsp_cnt_q, rsp_cnt_d;
    logic [1:0]               mode_q, mode_d;
    logic [FA_W-1:0]          base_q, base_d;
    logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
    logic [FA_W-1:0]          first_err_q, first_err_d;
    logic                     done_q, done_d;
    logic                     pass_q, pass_d;

    logic                     start_ok;
    logic                     wr_active;
    logic                     rd_active;
    logic                     rsp_valid;
    logic                     rsp_mismatch;
    logic                     req_last;
    logic [IDX_W-1:0]         rsp_cnt_inc;
    logic                     all_rsp;
    logic                     go_done;
    logic [DQ_BITWIDTH-1:0]   wr_data;
    logic [DQ_BITWIDTH-1:0]   exp_data;

`ifdef DDR3_TRAFFIC_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0]          wd_q, wd_d;
    logic                     timeout_q, timeout_d;
`endif

    assign start_ok  = start && (state_q == ST_IDLE || state_q == ST_DONE);
    assign wr_active = (state_q == ST_WRITE);
    assign rd_active = (state_q == ST_READ);
    // Responses are only meaningful while reads may be outstanding.
    assign rsp_valid    = o_user_data_valid && (state_q == ST_READ || state_q == ST_DRAIN);
    assign rsp_mismatch = rsp_valid && (o_user_data != exp_data);
    assign req_last     = (req_idx_q == IDX_W'(NUM_WORDS - 1));
    assign rsp_cnt_inc  = rsp_cnt_q + IDX_W'(rsp_valid);
    assign all_rsp      = (rsp_cnt_inc == IDX_W'(NUM_WORDS));

    ddr3_pattern_gen #(.DQ_BITWIDTH(DQ_BITWIDTH)) u_wr_gen (
        .clk    (clk),
        .resetn (resetn),
        .load   (start_ok),
        .step   (wr_active && ctrl_ready),
        .mode   (mode_q),
        .data   (wr_data)
    );

    ddr3_pattern_gen #(.DQ_BITWIDTH(DQ_BITWIDTH)) u_exp_gen (
        .clk    (clk),
        .resetn (resetn),
        .load   (start_ok),
        .step   (rsp_valid),
        .mode   (mode_q),
        .data   (exp_data)
    );

    always_comb begin
        state_d     = state_q;
        req_idx_d   = req_idx_q;
        rsp_cnt_d   = rsp_cnt_inc;
        mode_d      = mode_q;
        base_d      = base_q;
        err_cnt_d   = err_cnt_q;
        first_err_d = first_err_q;
        done_d      = done_q;
        pass_d      = pass_q;
        go_done     = 1'b0;

        if (rsp_mismatch) begin
            if (err_cnt_q != ERR_MAX) begin
                err_cnt_d = err_cnt_q + 1'b1;
            end
            // Counter saturates, so zero means no mismatch seen yet this run.
            if (err_cnt_q == '0) begin
                first_err_d = base_q + FA_W'(rsp_cnt_q);
            end
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d     = ST_WRITE;
                    req_idx_d   = '0;
                    rsp_cnt_d   = '0;
                    mode_d      = mode;
                    base_d      = base_address;
                    err_cnt_d   = '0;
                    first_err_d = '0;
                    done_d      = 1'b0;
                    pass_d      = 1'b0;
                end
            end
            ST_WRITE: begin
                if (ctrl_ready) begin
                    if (req_last) begin
                        state_d   = ST_READ;
                        req_idx_d = '0;
                    end else begin
                        req_idx_d = req_idx_q + 1'b1;
                    end
                end
            end
            ST_READ: begin
                if (ctrl_ready) begin
                    if (req_last) begin
                        req_idx_d = '0;
                        if (all_rsp) begin
                            go_done = 1'b1;
                        end else begin
                            state_d = ST_DRAIN;
                        end
                    end else begin
                        req_idx_d = req_idx_q + 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (all_rsp) begin
                    go_done = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

`ifdef DDR3_TRAFFIC_TIMEOUT_EN
        timeout_d = timeout_q;
        wd_d      = '0;
        if ((state_q == ST_READ || state_q == ST_DRAIN) && !rsp_valid) begin
            wd_d = wd_q + 1'b1;
            if (wd_q == WD_W'(TIMEOUT_CYCLES - 1) && !go_done) begin
                go_done   = 1'b1;
                timeout_d = 1'b1;
            end
        end
        if (start_ok) begin
            timeout_d = 1'b0;
        end
`endif

        if (go_done) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            pass_d  = (err_cnt_d == '0);
        end

`ifdef DDR3_TRAFFIC_TIMEOUT_EN
        if (timeout_d) begin
            pass_d = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            req_idx_q   <= '0;
            rsp_cnt_q   <= '0;
            mode_q      <= '0;
            base_q      <= '0;
            err_cnt_q   <= '0;
            first_err_q <= '0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_idx_q   <= req_idx_d;
            rsp_cnt_q   <= rsp_cnt_d;
            mode_q      <= mode_d;
            base_q      <= base_d;
            err_cnt_q   <= err_cnt_d;
            first_err_q <= first_err_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
        end
    end

`ifdef DDR3_TRAFFIC_TIMEOUT_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`endif

    assign write_enable        = wr_active;
    assign read_enable         = rd_active;
    assign i_user_data_address = (wr_active || rd_active) ? base_q + FA_W'(req_idx_q) : '0;
    assign i_user_data         = wr_active ? wr_data : '0;
    assign busy                = (state_q == ST_WRITE) || (state_q == ST_READ) || (state_q == ST_DRAIN);
    assign done                = done_q;
    assign pass                = pass_q;
    assign error_count         = err_cnt_q;
    assign first_err_address   = first_err_q;

endmodule

`default_nettype wire

// File: tb/tb_ddr3_traffic_checker.sv
// ============================================================================
// Module      : tb_ddr3_traffic_checker
// Description : Self-checking bench: memory/controller model with random
//               ready stalls and a pattern reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ddr3_traffic_checker;

    localparam int DQ = 16;
    localparam int AW = 15;
    localparam int BW = 3;
    localparam int FA = AW + BW;
    localparam int NW = 256;
    localparam int EW = 16;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          start = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic [FA-1:0] base_address = '0;
    logic          ctrl_ready = 1'b0;
    logic [DQ-1:0] o_user_data = '0;
    logic          o_user_data_valid = 1'b0;
    logic          write_enable, read_enable, busy, done, pass;
    logic [FA-1:0] i_user_data_address, first_err_address;
    logic [DQ-1:0] i_user_data;
    logic [EW-1:0] error_count;
`ifdef DDR3_TRAFFIC_TIMEOUT_EN
    logic          timeout;
`endif

    ddr3_traffic_checker #(
        .DQ_BITWIDTH(DQ), .ADDRESS_BITWIDTH(AW), .BANK_ADDRESS_BITWIDTH(BW),
        .NUM_WORDS(NW), .ERR_CNT_WIDTH(EW)
`ifdef DDR3_TRAFFIC_TIMEOUT_EN
        , .TIMEOUT_CYCLES(64)
`endif
    ) dut (
        .clk(clk), .resetn(resetn), .start(start), .mode(mode),
        .base_address(base_address), .write_enable(write_enable),
        .read_enable(read_enable), .i_user_data_address(i_user_data_address),
        .i_user_data(i_user_data), .ctrl_ready(ctrl_ready),
        .o_user_data(o_user_data), .o_user_data_valid(o_user_data_valid),
        .busy(busy), .done(done), .pass(pass), .error_count(error_count),
`ifdef DDR3_TRAFFIC_TIMEOUT_EN
        .timeout(timeout),
`endif
        .first_err_address(first_err_address)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: pattern words computed straight from the pattern rules.
    logic [31:0] lfsr_tbl [0:NW-1];

    function automatic logic [DQ-1:0] ref_word(input int m, input int i);
        logic [DQ-1:0] one;
        one = 1;
        case (m)
            0:       return DQ'(i);
            1:       return lfsr_tbl[i][DQ-1:0];
            2:       return one << (i % DQ);
            default: return (i % 2 == 0) ? 16'h5555 : 16'hAAAA;
        endcase
    endfunction

    // Memory/controller model and scoreboard state.
    typedef struct { int due; logic [DQ-1:0] data; } rsp_t;
    rsp_t          rq[$];
    logic [DQ-1:0] mem [logic [FA-1:0]];
    int            exp_mode;
    logic [FA-1:0] exp_base;
    int            wr_cnt, rd_cnt, wr_bad, rd_bad, stall_bad, rsp_sent;
    int            rsp_limit = NW;
    bit            rand_ready = 1'b0;
    bit            corrupt [0:NW-1];
    logic [FA-1:0] wr_addr_log [0:NW-1];
    logic [DQ-1:0] wr_data_log [0:NW-1];
    int            cyc = 0;
    int            last_rsp_cyc = 0;

    initial begin : ctrl_model
        bit            prev_pend;
        logic [FA-1:0] prev_addr;
        logic [DQ-1:0] prev_data;
        logic [DQ-1:0] d;
        rsp_t          r;
        prev_pend = 1'b0;
        prev_addr = '0;
        prev_data = '0;
        forever begin
            @(negedge clk);
            #1;
            cyc++;
            o_user_data_valid = 1'b0;
            o_user_data       = '0;
            if (!resetn) begin
                rq.delete();
                prev_pend  = 1'b0;
                ctrl_ready = 1'b0;
            end else begin
                if (rq.size() > 0 && rq[0].due <= cyc) begin
                    r = rq.pop_front();
                    o_user_data_valid = 1'b1;
                    o_user_data       = r.data;
                    last_rsp_cyc      = cyc;
                    rsp_sent++;
                end
                ctrl_ready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
                if (prev_pend && (write_enable || read_enable)) begin
                    if (i_user_data_address !== prev_addr || i_user_data !== prev_data) stall_bad++;
                end
                if ((write_enable || read_enable) && ctrl_ready) begin
                    prev_pend = 1'b0;
                    if (write_enable) begin
                        if (wr_cnt < NW) begin
                            wr_addr_log[wr_cnt] = i_user_data_address;
                            wr_data_log[wr_cnt] = i_user_data;
                            if (i_user_data_address !== exp_base + FA'(wr_cnt)) wr_bad++;
                            if (i_user_data !== ref_word(exp_mode, wr_cnt)) wr_bad++;
                        end
                        mem[i_user_data_address] = i_user_data;
                        wr_cnt++;
                    end else begin
                        if (i_user_data_address !== exp_base + FA'(rd_cnt)) rd_bad++;
                        d = mem.exists(i_user_data_address) ? mem[i_user_data_address] : '0;
                        if (rd_cnt < NW && corrupt[rd_cnt]) d = d ^ DQ'(1);
                        if (rd_cnt < rsp_limit) begin
                            r.due  = cyc + 2;
                            r.data = d;
                            rq.push_back(r);
                        end
                        rd_cnt++;
                    end
                end else begin
                    prev_pend = write_enable || read_enable;
                    prev_addr = i_user_data_address;
                    prev_data = i_user_data;
                end
            end
        end
    end

    // Stimulus helpers (no checking inside).
    task automatic prep(input int m, input logic [FA-1:0] b, input bit rr);
        exp_mode = m; exp_base = b; rand_ready = rr;
        wr_cnt = 0; rd_cnt = 0; wr_bad = 0; rd_bad = 0; stall_bad = 0; rsp_sent = 0;
        rsp_limit = NW;
        mem.delete();
        for (int i = 0; i < NW; i++) corrupt[i] = 1'b0;
    endtask

    task automatic start_run(input int m, input logic [FA-1:0] b);
        @(negedge clk);
        mode = m[1:0]; base_address = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc, output bit ok, output int done_cyc);
        ok = 1'b0; done_cyc = 0;
        for (int k = 0; k < max_cyc; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin ok = 1'b1; done_cyc = cyc; break; end
        end
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        #23;
        checks++; if (write_enable !== 1'b0) begin failures++; $display("FAIL rst_we: got %b expected 0", write_enable); end
        checks++; if (read_enable !== 1'b0) begin failures++; $display("FAIL rst_re: got %b expected 0", read_enable); end
        checks++; if (i_user_data_address !== '0) begin failures++; $display("FAIL rst_addr: got %h expected 0", i_user_data_address); end
        checks++; if (i_user_data !== '0) begin failures++; $display("FAIL rst_data: got %h expected 0", i_user_data); end
        checks++; if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0) begin failures++; $display("FAIL rst_status: got busy=%b done=%b pass=%b expected 0 0 0", busy, done, pass); end
        checks++; if (error_count !== '0 || first_err_address !== '0) begin failures++; $display("FAIL rst_err: got cnt=%h first=%h expected 0 0", error_count, first_err_address); end
`ifdef DDR3_TRAFFIC_TIMEOUT_EN
        checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL rst_timeout: got %b expected 0", timeout); end
`endif
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_ideal_increment;
        bit ok; int dc;
        prep(0, '0, 1'b0);
        start_run(0, '0);
        wait_done(5000, ok, dc);
        checks++; if (!ok) begin failures++; $display("FAIL ideal_done: got no done expected done within 5000 cycles"); end
        checks++; if (wr_cnt !== NW || rd_cnt !== NW) begin failures++; $display("FAIL ideal_counts: got wr=%0d rd=%0d expected %0d", wr_cnt, rd_cnt, NW); end
        checks++; if (wr_bad !== 0 || rd_bad !== 0) begin failures++; $display("FAIL ideal_stream: got wr_bad=%0d rd_bad=%0d expected 0", wr_bad, rd_bad); end
        checks++; if (wr_addr_log[255] !== FA'(255) || wr_data_log[255] !== DQ'(255)) begin failures++; $display("FAIL ideal_last_word: got addr=%h data=%h expected ff ff", wr_addr_log[255], wr_data_log[255]); end
        checks++; if (done !== 1'b1 || busy !== 1'b0 || pass !== 1'b1) begin failures++; $display("FAIL ideal_status: got done=%b busy=%b pass=%b expected 1 0 1", done, busy, pass); end
        checks++; if (error_count !== '0) begin failures++; $display("FAIL ideal_errcnt: got %0d expected 0", error_count); end
        checks++; if (rsp_sent !== NW) begin failures++; $display("FAIL ideal_responses: got %0d expected %0d", rsp_sent, NW); end
    endtask

    task automatic test_random_ready;
        bit ok; int dc; logic [FA-1:0] b;
        for (int m = 0; m < 4; m++) begin
            b = FA'($urandom);
            prep(m, b, 1'b1);
            start_run(m, b);
            wait_done(8000, ok, dc);
            checks++; if (!ok) begin failures++; $display("FAIL rand_done m%0d: got no done expected done", m); end
            checks++; if (wr_cnt !== NW || rd_cnt !== NW) begin failures++; $display("FAIL rand_counts m%0d: got wr=%0d rd=%0d expected %0d", m, wr_cnt, rd_cnt, NW); end
            checks++; if (wr_bad !== 0 || rd_bad !== 0) begin failures++; $display("FAIL rand_stream m%0d: got wr_bad=%0d rd_bad=%0d expected 0", m, wr_bad, rd_bad); end
            checks++; if (stall_bad !== 0) begin failures++; $display("FAIL rand_hold m%0d: got %0d unstable stalls expected 0", m, stall_bad); end
            checks++; if (pass !== 1'b1 || error_count !== '0) begin failures++; $display("FAIL rand_pass m%0d: got pass=%b cnt=%0d expected 1 0", m, pass, error_count); end
        end
    endtask

    task automatic test_lfsr_corrupt;
        bit ok; int dc; logic [FA-1:0] b;
        b = FA'($urandom);
        prep(1, b, 1'b0);
        corrupt[5] = 1'b1;
        start_run(1, b);
        wait_done(5000, ok, dc);
        checks++; if (!ok) begin failures++; $display("FAIL lfsr_done: got no done expected done"); end
        checks++; if (wr_bad !== 0) begin failures++; $display("FAIL lfsr_stream: got %0d bad writes expected 0", wr_bad); end
        checks++; if (error_count !== EW'(1)) begin failures++; $display("FAIL lfsr_errcnt: got %0d expected 1", error_count); end
        checks++; if (first_err_address !== b + FA'(5)) begin failures++; $display("FAIL lfsr_first: got %h expected %h", first_err_address, b + FA'(5)); end
        checks++; if (pass !== 1'b0 || done !== 1'b1) begin failures++; $display("FAIL lfsr_status: got pass=%b done=%b expected 0 1", pass, done); end
    endtask

    task automatic test_wrap;
        bit ok; int dc; logic [FA-1:0] b;
        b = '1;
        b = b - FA'(3);
        prep(2, b, 1'b0);
        start_run(2, b);
        wait_done(5000, ok, dc);
        checks++; if (!ok) begin failures++; $display("FAIL wrap_done: got no done expected done"); end
        checks++; if (wr_addr_log[3] !== {FA{1'b1}} || wr_addr_log[4] !== '0) begin failures++; $display("FAIL wrap_addr: got %h,%h expected all-ones,0", wr_addr_log[3], wr_addr_log[4]); end
        for (int i = 0; i < 5; i++) begin
            checks++; if (wr_data_log[i] !== DQ'(1 << i)) begin failures++; $display("FAIL wrap_data%0d: got %h expected %h", i, wr_data_log[i], DQ'(1 << i)); end
        end
        checks++; if (wr_bad !== 0 || rd_bad !== 0 || pass !== 1'b1) begin failures++; $display("FAIL wrap_run: got wr_bad=%0d rd_bad=%0d pass=%b expected 0 0 1", wr_bad, rd_bad, pass); end
    endtask

    task automatic test_start_ignored;
        bit ok; int dc; logic [FA-1:0] b;
        b = FA'($urandom);
        prep(0, b, 1'b0);
        start_run(0, b);
        repeat (20) @(negedge clk);
        mode = 2'd3; base_address = ~b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(5000, ok, dc);
        checks++; if (!ok) begin failures++; $display("FAIL ign_done: got no done expected done"); end
        checks++; if (wr_cnt !== NW || rd_cnt !== NW) begin failures++; $display("FAIL ign_counts: got wr=%0d rd=%0d expected %0d", wr_cnt, rd_cnt, NW); end
        checks++; if (wr_bad !== 0 || rd_bad !== 0) begin failures++; $display("FAIL ign_stream: got wr_bad=%0d rd_bad=%0d expected 0", wr_bad, rd_bad); end
        checks++; if (pass !== 1'b1) begin failures++; $display("FAIL ign_pass: got %b expected 1", pass); end
    endtask

    task automatic test_back_to_back;
        bit ok; int dc; int n; int first; int idx; logic [FA-1:0] b;
        b = FA'($urandom);
        prep(3, b, 1'b1);
        n = 0; first = NW;
        for (int k = 0; k < 5; k++) begin
            idx = $urandom_range(0, NW - 1);
            if (!corrupt[idx]) begin corrupt[idx] = 1'b1; n++; if (idx < first) first = idx; end
        end
        start_run(3, b);
        wait_done(8000, ok, dc);
        checks++; if (!ok) begin failures++; $display("FAIL b2b_done: got no done expected done"); end
        checks++; if (error_count !== EW'(n)) begin failures++; $display("FAIL b2b_errcnt: got %0d expected %0d", error_count, n); end
        checks++; if (first_err_address !== b + FA'(first)) begin failures++; $display("FAIL b2b_first: got %h expected %h", first_err_address, b + FA'(first)); end
        checks++; if (pass !== 1'b0) begin failures++; $display("FAIL b2b_pass: got %b expected 0", pass); end
        b = FA'($urandom);
        prep(0, b, 1'b0);
        start_run(0, b);
        checks++; if (done !== 1'b0 || busy !== 1'b1 || error_count !== '0) begin failures++; $display("FAIL restart_clear: got done=%b busy=%b cnt=%0d expected 0 1 0", done, busy, error_count); end
        wait_done(5000, ok, dc);
        checks++; if (!ok || pass !== 1'b1 || error_count !== '0) begin failures++; $display("FAIL restart_run: got ok=%b pass=%b cnt=%0d expected 1 1 0", ok, pass, error_count); end
    endtask

    task automatic test_reset_mid_run;
        logic [FA-1:0] b;
        b = FA'($urandom);
        prep(1, b, 1'b0);
        start_run(1, b);
        repeat (300) @(negedge clk);
        #2;
        resetn = 1'b0;
        #1;
        checks++; if (write_enable !== 1'b0 || read_enable !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL midrst_ctrl: got we=%b re=%b busy=%b expected 0 0 0", write_enable, read_enable, busy); end
        checks++; if (i_user_data_address !== '0 || i_user_data !== '0) begin failures++; $display("FAIL midrst_bus: got addr=%h data=%h expected 0 0", i_user_data_address, i_user_data); end
        checks++; if (done !== 1'b0 || pass !== 1'b0 || error_count !== '0 || first_err_address !== '0) begin failures++; $display("FAIL midrst_status: got done=%b pass=%b cnt=%0d first=%h expected all 0", done, pass, error_count, first_err_address); end
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
    endtask

`ifdef DDR3_TRAFFIC_TIMEOUT_EN
    task automatic test_timeout;
        bit ok; int dc; logic [FA-1:0] b;
        b = FA'($urandom);
        prep(0, b, 1'b0);
        rsp_limit = 11;
        start_run(0, b);
        wait_done(5000, ok, dc);
        checks++; if (!ok) begin failures++; $display("FAIL to_done: got no done expected done"); end
        checks++; if (dc - last_rsp_cyc !== 64) begin failures++; $display("FAIL to_latency: got %0d cycles expected 64", dc - last_rsp_cyc); end
        checks++; if (timeout !== 1'b1 || pass !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL to_status: got timeout=%b pass=%b busy=%b expected 1 0 0", timeout, pass, busy); end
        prep(0, b, 1'b0);
        start_run(0, b);
        checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL to_clear: got %b expected 0", timeout); end
        wait_done(5000, ok, dc);
    endtask
`endif

    initial begin
        logic [31:0] l;
        l = 32'hACE1_0001;
        for (int i = 0; i < NW; i++) begin
            lfsr_tbl[i] = l;
            l = {l[30:0], l[31] ^ l[21] ^ l[1] ^ l[0]};
        end
        test_reset();
        test_ideal_increment();
        test_random_ready();
        test_lfsr_corrupt();
        test_wrap();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid_run();
`ifdef DDR3_TRAFFIC_TIMEOUT_EN
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
